// File: rtl/hdd_xfer_ctrl.sv
// hdd_xfer_ctrl
// Sequences one 512-byte block transfer between the host block-device port
// and the ProDOS HDD card's dual-ported sector RAM. A rising edge on the
// card's read or write request level raises a host request for the card's
// block number. The controller then steers the host buffer port onto the
// sector RAM port until the host drops sd_ack. The CPU is held in halt
// from request acceptance until the cycle after the transfer finishes.
// The controller also tracks the image mounted/read-only status.
//
// Ports
//   CLK_14M, RESET_N          : clock, asynchronous active-low reset
//   hdd_read, hdd_write       : request levels from the card (edge-detected)
//   sector                    : ProDOS block number from the card
//   hdd_mounted, hdd_protect  : image status back to the card
//   ram_addr/ram_di/ram_we    : sector RAM port driven toward the card
//   ram_do                    : sector RAM read data (1-cycle latency)
//   img_mounted/readonly/size : host mount strobe and image attributes
//   sd_lba, sd_rd, sd_wr      : host block request
//   sd_ack                    : host acknowledge, high for the whole transfer
//   sd_buff_addr/dout/din/wr  : host byte stream
//   cpu_halt                  : CPU stall while a request is in flight
//   xfer_err                  : sticky error, cleared by the next accepted request
module hdd_xfer_ctrl #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd14000000,
   parameter int          BLOCK_BYTES    = 512
) (
   input  logic        CLK_14M,
   input  logic        RESET_N,
   input  logic        hdd_read,
   input  logic        hdd_write,
   input  logic [15:0] sector,
   output logic        hdd_mounted,
   output logic        hdd_protect,
   output logic [8:0]  ram_addr,
   output logic [7:0]  ram_di,
   input  logic [7:0]  ram_do,
   output logic        ram_we,
   input  logic        img_mounted,
   input  logic        img_readonly,
   input  logic [63:0] img_size,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   input  logic        sd_ack,
   input  logic [8:0]  sd_buff_addr,
   input  logic [7:0]  sd_buff_dout,
   output logic [7:0]  sd_buff_din,
   input  logic        sd_buff_wr,
   output logic        cpu_halt,
   output logic        xfer_err
);

   typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

   localparam logic [9:0]  BYTE_LIMIT = 10'(BLOCK_BYTES);
   localparam logic [9:0]  BYTE_SAT   = 10'h3FF;
   localparam logic [23:0] TMO_LAST   = TIMEOUT_CYCLES - 24'd1;

   state_t      state, state_next;
   logic        dir, dir_next;            // 0 = read (host to card), 1 = write
   logic [31:0] lba, lba_next;
   logic        err, err_next;
   logic        mounted, mounted_next;
   logic        protect, protect_next;
   logic        read_prev, write_prev;
   logic [9:0]  byte_cnt, byte_cnt_next;
   logic [23:0] tmo_cnt, tmo_cnt_next;

   logic read_edge, write_edge, any_edge, tmo_hit;

   assign read_edge  = hdd_read  & ~read_prev;
   assign write_edge = hdd_write & ~write_prev;
   assign any_edge   = read_edge | write_edge;
   assign tmo_hit    = (tmo_cnt == TMO_LAST);

   always_ff @(posedge CLK_14M or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= IDLE;
         dir        <= 1'b0;
         lba        <= 32'h0;
         err        <= 1'b0;
         mounted    <= 1'b0;
         protect    <= 1'b0;
         read_prev  <= 1'b0;
         write_prev <= 1'b0;
         byte_cnt   <= 10'h0;
         tmo_cnt    <= 24'h0;
      end else begin
         state      <= state_next;
         dir        <= dir_next;
         lba        <= lba_next;
         err        <= err_next;
         mounted    <= mounted_next;
         protect    <= protect_next;
         read_prev  <= hdd_read;
         write_prev <= hdd_write;
         byte_cnt   <= byte_cnt_next;
         tmo_cnt    <= tmo_cnt_next;
      end
   end

   always_comb begin
      state_next    = state;
      dir_next      = dir;
      lba_next      = lba;
      err_next      = err;
      mounted_next  = mounted;
      protect_next  = protect;
      byte_cnt_next = byte_cnt;
      tmo_cnt_next  = tmo_cnt;

      // Mount status updates in every state; a remount mid-transfer does
      // not disturb the transfer in progress.
      if (img_mounted) begin
         mounted_next = |img_size;
         protect_next = img_readonly;
      end

      case (state)
         IDLE: begin
            // Read wins a simultaneous edge pair; the collision is flagged.
            // Write-protect uses the status held before this cycle's strobe.
            if (read_edge || (write_edge && !protect)) begin
               dir_next      = ~read_edge;
               lba_next      = {16'h0, sector};
               err_next      = read_edge & write_edge;
               byte_cnt_next = 10'h0;
               tmo_cnt_next  = 24'h0;
               state_next    = REQ;
            end
         end

         REQ: begin
            if (any_edge) err_next = 1'b1;
            if (sd_ack) begin
               tmo_cnt_next = 24'h0;
               state_next   = XFER;
            end else if (tmo_hit) begin
               err_next   = 1'b1;
               state_next = DONE;
            end else begin
               tmo_cnt_next = tmo_cnt + 24'd1;
            end
         end

         XFER: begin
            if (any_edge) err_next = 1'b1;
            if (!dir && sd_buff_wr && byte_cnt != BYTE_SAT)
               byte_cnt_next = byte_cnt + 10'd1;
            if (!sd_ack) begin
               // A read must have delivered exactly one block.
               if (!dir && byte_cnt != BYTE_LIMIT) err_next = 1'b1;
               state_next = DONE;
            end else if (tmo_hit) begin
               err_next   = 1'b1;
               state_next = DONE;
            end else begin
               tmo_cnt_next = tmo_cnt + 24'd1;
            end
         end

         DONE: begin
            if (any_edge) err_next = 1'b1;
            state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   // Outputs decode straight from registered state so the asynchronous
   // reset clears them without waiting for a clock edge.
   assign cpu_halt    = (state != IDLE);
   assign sd_rd       = (state == REQ) && !dir;
   assign sd_wr       = (state == REQ) &&  dir;
   assign sd_lba      = lba;
   assign xfer_err    = err;
   assign hdd_mounted = mounted;
   assign hdd_protect = protect;

   // During XFER the host byte port is wired straight onto the sector RAM.
   assign ram_we      = (state == XFER && !dir) ? sd_buff_wr   : 1'b0;
   assign ram_addr    = (state == XFER)         ? sd_buff_addr : 9'h0;
   assign ram_di      = (state == XFER && !dir) ? sd_buff_dout : 8'h0;
   assign sd_buff_din = (state == XFER &&  dir) ? ram_do       : 8'h0;

endmodule

// File: tb/tb_hdd_xfer_ctrl.sv
`timescale 1ns/1ps
module tb_hdd_xfer_ctrl;

   localparam logic [23:0] TMO_MAIN  = 24'd2000;
   localparam logic [23:0] TMO_SHORT = 24'd100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // shared / main-instance stimulus
   logic        rst_n;
   logic        hdd_read, hdd_write;
   logic [15:0] sector;
   logic [7:0]  ram_do;
   logic        img_mounted, img_readonly;
   logic [63:0] img_size;
   logic        sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic        sd_buff_wr;

   // main-instance outputs
   logic        hdd_mounted, hdd_protect, ram_we, sd_rd, sd_wr, cpu_halt, xfer_err;
   logic [8:0]  ram_addr;
   logic [7:0]  ram_di, sd_buff_din;
   logic [31:0] sd_lba;

   // short-timeout instance
   logic        t_read;
   logic        t_mounted, t_protect, t_ram_we, t_sd_rd, t_sd_wr, t_halt, t_err;
   logic [8:0]  t_ram_addr;
   logic [7:0]  t_ram_di, t_din;
   logic [31:0] t_lba;

   hdd_xfer_ctrl #(.TIMEOUT_CYCLES(TMO_MAIN), .BLOCK_BYTES(512)) u_dut (
      .CLK_14M(clk), .RESET_N(rst_n),
      .hdd_read(hdd_read), .hdd_write(hdd_write), .sector(sector),
      .hdd_mounted(hdd_mounted), .hdd_protect(hdd_protect),
      .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do), .ram_we(ram_we),
      .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
      .cpu_halt(cpu_halt), .xfer_err(xfer_err)
   );

   hdd_xfer_ctrl #(.TIMEOUT_CYCLES(TMO_SHORT), .BLOCK_BYTES(512)) u_dut_tmo (
      .CLK_14M(clk), .RESET_N(rst_n),
      .hdd_read(t_read), .hdd_write(1'b0), .sector(16'h0042),
      .hdd_mounted(t_mounted), .hdd_protect(t_protect),
      .ram_addr(t_ram_addr), .ram_di(t_ram_di), .ram_do(8'h00), .ram_we(t_ram_we),
      .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
      .sd_lba(t_lba), .sd_rd(t_sd_rd), .sd_wr(t_sd_wr), .sd_ack(1'b0),
      .sd_buff_addr(9'h0), .sd_buff_dout(8'h00),
      .sd_buff_din(t_din), .sd_buff_wr(1'b0),
      .cpu_halt(t_halt), .xfer_err(t_err)
   );

   // Card-side sector RAM: synchronous write, registered read.
   logic [7:0] card_ram [512];
   logic       preload_req;
   always @(posedge clk) begin
      if (preload_req) begin
         for (int i = 0; i < 512; i++) card_ram[i] <= 8'(i);
      end else if (ram_we) begin
         card_ram[ram_addr] <= ram_di;
      end
      ram_do <= card_ram[ram_addr];
   end

   // Activity counters used by the directed checks.
   int   rd_rises = 0, wr_rises = 0, we_count = 0;
   logic sd_rd_q = 1'b0, sd_wr_q = 1'b0;
   always @(posedge clk) begin
      sd_rd_q <= sd_rd;
      sd_wr_q <= sd_wr;
      if (sd_rd && !sd_rd_q) rd_rises <= rd_rises + 1;
      if (sd_wr && !sd_wr_q) wr_rises <= wr_rises + 1;
      if (ram_we)            we_count <= we_count + 1;
   end

   // ------------------------------------------------------------------
   // Reference model of the main instance. The transaction is tracked as
   // a phase (0 idle, 1 awaiting host ack, 2 moving bytes, 3 wrap-up),
   // the phase age comes from a free-running cycle stamp, and error is
   // one boolean expression over this cycle's events.
   // ------------------------------------------------------------------
   int          cyc, m_since, m_bytes, m_mode, m_age;
   logic        m_dir, m_err, m_mnt, m_prot, m_prev_rd, m_prev_wr;
   logic [31:0] m_lba;
   logic        r_rise, w_rise, accept, expired, short_block, err_now;

   assign r_rise      = hdd_read  && !m_prev_rd;
   assign w_rise      = hdd_write && !m_prev_wr;
   assign accept      = (m_mode == 0) && (r_rise || (w_rise && !m_prot));
   assign m_age       = cyc - m_since;
   assign expired     = ((m_mode == 1 && !sd_ack) || (m_mode == 2 && sd_ack))
                        && (m_age == int'(TMO_MAIN) - 1);
   assign short_block = (m_mode == 2) && !sd_ack && !m_dir && (m_bytes != 512);
   assign err_now     = accept ? (r_rise && w_rise)
                      : (m_err || (m_mode != 0 && (r_rise || w_rise)) || expired || short_block);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= 0; m_since <= 0; m_bytes <= 0; m_mode <= 0;
         m_dir <= 1'b0; m_err <= 1'b0; m_mnt <= 1'b0; m_prot <= 1'b0;
         m_prev_rd <= 1'b0; m_prev_wr <= 1'b0; m_lba <= 32'h0;
      end else begin
         cyc       <= cyc + 1;
         m_prev_rd <= hdd_read;
         m_prev_wr <= hdd_write;
         m_err     <= err_now;
         if (img_mounted) begin
            m_mnt  <= (img_size != 64'd0);
            m_prot <= img_readonly;
         end
         if (m_mode == 2 && !m_dir && sd_buff_wr && m_bytes < 1023)
            m_bytes <= m_bytes + 1;
         if (accept) begin
            m_dir   <= !r_rise;
            m_lba   <= {16'h0, sector};
            m_bytes <= 0;
            m_since <= cyc + 1;
            m_mode  <= 1;
         end else if (m_mode == 1 && sd_ack) begin
            m_since <= cyc + 1;
            m_mode  <= 2;
         end else if ((m_mode == 2 && !sd_ack) || expired || m_mode == 3) begin
            m_mode  <= (m_mode == 3) ? 0 : 3;
         end
      end
   end

   // ------------------------------------------------------------------
   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         chk("cyc_halt",  cpu_halt,    m_mode != 0);
         chk("cyc_sd_rd", sd_rd,       m_mode == 1 && !m_dir);
         chk("cyc_sd_wr", sd_wr,       m_mode == 1 &&  m_dir);
         chk("cyc_lba",   sd_lba,      m_lba);
         chk("cyc_err",   xfer_err,    m_err);
         chk("cyc_mnt",   hdd_mounted, m_mnt);
         chk("cyc_prot",  hdd_protect, m_prot);
         chk("cyc_we",    ram_we,      (m_mode == 2 && !m_dir) ? sd_buff_wr : 1'b0);
         chk("cyc_addr",  ram_addr,    (m_mode == 2) ? sd_buff_addr : 9'h0);
         chk("cyc_di",    ram_di,      (m_mode == 2 && !m_dir) ? sd_buff_dout : 8'h0);
         chk("cyc_din",   sd_buff_din, (m_mode == 2 &&  m_dir) ? ram_do : 8'h0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mount(input logic [63:0] size, input logic ro);
      img_size = size; img_readonly = ro; img_mounted = 1'b1;
      tick();
      img_mounted = 1'b0;
   endtask

   // Host side of a read: ack, then nstrobes bytes of value index^A5.
   task automatic host_read(input logic [15:0] sec, input int nstrobes, input logic exp_err);
      int rd0, we0, nbad;
      rd0 = rd_rises; we0 = we_count;
      hdd_read = 1'b1; sector = sec;
      tick();
      chk("rd_req",  sd_rd, 1'b1);
      chk("rd_lba",  sd_lba, {16'h0, sec});
      chk("rd_halt", cpu_halt, 1'b1);
      chk("rd_clr",  xfer_err, 1'b0);
      tick(); tick();
      sd_ack = 1'b1;
      tick();
      for (int i = 0; i < nstrobes; i++) begin
         sd_buff_wr = 1'b1; sd_buff_addr = 9'(i); sd_buff_dout = 8'(i) ^ 8'hA5;
         if (i == 6) hdd_read = 1'b0;
         tick();
      end
      sd_buff_wr = 1'b0; hdd_read = 1'b0; sd_ack = 1'b0;
      tick();
      chk("rd_halt_done", cpu_halt, 1'b1);
      tick();
      chk("rd_halt_low", cpu_halt, 1'b0);
      chk("rd_err",      xfer_err, exp_err);
      chk("rd_pulses",   rd_rises - rd0, 1);
      chk("we_pulses",   we_count - we0, nstrobes);
      nbad = 0;
      for (int i = 0; i < nstrobes; i++)
         if (card_ram[i] !== (8'(i) ^ 8'hA5)) nbad++;
      chk("rd_data_bad", nbad, 0);
   endtask

   initial begin
      int wr0, nbad, n;
      rst_n = 1'b0; hdd_read = 1'b0; hdd_write = 1'b0; sector = 16'h0;
      img_mounted = 1'b0; img_readonly = 1'b0; img_size = 64'h0;
      sd_ack = 1'b0; sd_buff_addr = 9'h0; sd_buff_dout = 8'h0; sd_buff_wr = 1'b0;
      t_read = 1'b0; preload_req = 1'b0;
      fork
         compare_loop();
      join_none
      repeat (3) tick();
      chk("rst_halt", cpu_halt, 1'b0);
      chk("rst_rd",   sd_rd, 1'b0);
      chk("rst_lba",  sd_lba, 32'h0);
      chk("rst_err",  xfer_err, 1'b0);
      chk("rst_mnt",  hdd_mounted, 1'b0);
      rst_n = 1'b1;
      tick();

      // mount handling
      mount(64'h200000, 1'b0);
      chk("mnt_on",   hdd_mounted, 1'b1);
      chk("mnt_prot", hdd_protect, 1'b0);
      mount(64'h0, 1'b0);
      chk("mnt_zero", hdd_mounted, 1'b0);
      mount(64'h200000, 1'b0);

      // full block read
      host_read(16'h0123, 512, 1'b0);
      chk("rd_lba_lit", sd_lba, 32'h0000_0123);

      // block write: card RAM holds i&FF, host reads it back
      preload_req = 1'b1; tick(); preload_req = 1'b0;
      wr0 = wr_rises;
      hdd_write = 1'b1; sector = 16'h0007;
      tick();
      chk("wr_req",   sd_wr, 1'b1);
      chk("wr_no_rd", sd_rd, 1'b0);
      chk("wr_lba",   sd_lba, 32'h7);
      hdd_write = 1'b0;
      tick();
      sd_ack = 1'b1; sd_buff_addr = 9'h0;
      tick();
      nbad = 0;
      for (int a = 0; a < 512; a++) begin
         sd_buff_addr = 9'(a);
         tick();
         if (sd_buff_din !== 8'(a)) nbad++;
         if (a == 255) chk("wr_din_255", sd_buff_din, 8'hFF);
         if (a == 256) chk("wr_din_256", sd_buff_din, 8'h00);
      end
      chk("wr_din_bad", nbad, 0);
      sd_ack = 1'b0;
      tick(); tick();
      chk("wr_halt_low", cpu_halt, 1'b0);
      chk("wr_err",      xfer_err, 1'b0);
      chk("wr_pulses",   wr_rises - wr0, 1);

      // write to a read-only image is rejected
      mount(64'h200000, 1'b1);
      chk("ro_prot", hdd_protect, 1'b1);
      wr0 = wr_rises;
      hdd_write = 1'b1;
      tick();
      chk("ro_no_wr",   sd_wr, 1'b0);
      chk("ro_no_halt", cpu_halt, 1'b0);
      repeat (5) tick();
      hdd_write = 1'b0;
      tick();
      chk("ro_wr_count", wr_rises - wr0, 0);
      mount(64'h200000, 1'b0);

      // simultaneous read and write edges: read served, error flagged
      hdd_read = 1'b1; hdd_write = 1'b1; sector = 16'h0300;
      tick();
      chk("both_rd",  sd_rd, 1'b1);
      chk("both_wr",  sd_wr, 1'b0);
      chk("both_err", xfer_err, 1'b1);
      hdd_read = 1'b0; hdd_write = 1'b0; sd_ack = 1'b1;
      tick();
      sd_ack = 1'b0;
      tick(); tick();
      chk("both_idle", cpu_halt, 1'b0);

      // one byte short of a block
      host_read(16'h0010, 511, 1'b1);

      // host never acks (short-timeout instance)
      t_read = 1'b1;
      tick();
      chk("tmo_rd",  t_sd_rd, 1'b1);
      chk("tmo_lba", t_lba, 32'h42);
      n = 0;
      while (t_sd_rd && n < 300) begin
         n++;
         tick();
      end
      chk("tmo_len",  n, 100);
      chk("tmo_err",  t_err, 1'b1);
      chk("tmo_done", t_halt, 1'b1);
      tick();
      chk("tmo_idle", t_halt, 1'b0);
      t_read = 1'b0;
      tick();
      t_read = 1'b1;
      tick();
      chk("tmo_again", t_sd_rd, 1'b1);
      chk("tmo_clr",   t_err, 1'b0);
      t_read = 1'b0;

      // reset in the middle of a transfer
      hdd_read = 1'b1; sector = 16'h0055;
      tick(); tick();
      sd_ack = 1'b1;
      tick();
      sd_buff_wr = 1'b1; sd_buff_addr = 9'h0; sd_buff_dout = 8'h11;
      tick();
      sd_buff_addr = 9'h1;
      tick();
      chk("mid_we", ram_we, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rd",   sd_rd, 1'b0);
      chk("rst_mid_halt", cpu_halt, 1'b0);
      chk("rst_mid_we",   ram_we, 1'b0);
      chk("rst_mid_lba",  sd_lba, 32'h0);
      hdd_read = 1'b0; sd_buff_wr = 1'b0; sd_ack = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      host_read(16'h0200, 512, 1'b0);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
